// File: rtl/poly1305_mac_core_if.sv
// Handshake bundle for poly1305_mac_core: one-time key load, message block
// stream and tag return, each a valid/ready channel.
interface poly1305_mac_core_if;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic [4:0]   blk_len;
    logic         blk_last;
    logic         tag_valid;
    logic         tag_ready;
    logic [127:0] tag;

    modport master (
        output key_valid, key, blk_valid, blk_data, blk_len, blk_last, tag_ready,
        input  key_ready, blk_ready, tag_valid, tag
    );

    modport slave (
        input  key_valid, key, blk_valid, blk_data, blk_len, blk_last, tag_ready,
        output key_ready, blk_ready, tag_valid, tag
    );
endinterface

// File: rtl/poly1305_mac_core.sv
// Streaming Poly1305 MAC: key load, per-block (acc + m) * r mod 2^130-5 with a
// digit-serial multiplier, final full reduction plus s, and tag handshake.
module poly1305_mac_core #(
    parameter int DIGIT_W = 32,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    poly1305_mac_core_if.slave mac_bus,
    output logic               busy,
    output logic               len_err,
    output logic [COUNT_W-1:0] blk_count
);

    localparam int N = 128 / DIGIT_W;
    localparam logic [127:0] R_CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    localparam logic [129:0] P_MOD   = {2'b11, {31{4'hf}}, 4'hb};

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WAIT_BLK = 4'd1,
        ADD      = 4'd2,
        MUL      = 4'd3,
        RED1     = 4'd4,
        RED2     = 4'd5,
        FIN1     = 4'd6,
        FIN2     = 4'd7,
        OUT      = 4'd8
    } state_t;

    function automatic logic [127:0] byte_mask(input logic [4:0] len);
        byte_mask = 128'd0;
        for (int i = 0; i < 16; i++) begin
            byte_mask[i*8 +: 8] = (5'(i) < len) ? 8'hff : 8'h00;
        end
    endfunction

    state_t               state_r;
    state_t               next_s;
    logic [127:0]         r_r;
    logic [127:0]         s_r;
    logic [130:0]         acc_r;
    logic [131:0]         x_r;
    logic [259:0]         p_r;
    logic [132:0]         t_r;
    logic [130:0]         f_r;
    logic [7:0]           k_r;
    logic [127:0]         data_r;
    logic [4:0]           len_r;
    logic                 last_r;
    logic [127:0]         tag_r;
    logic                 key_ready_r;
    logic                 blk_ready_r;
    logic                 tag_valid_r;
    logic                 busy_r;
    logic                 len_err_r;
    logic [COUNT_W-1:0]   blk_count_r;

    logic                 key_acc_s;
    logic                 blk_acc_s;
    logic                 tag_acc_s;
    logic                 len_ok_s;
    logic [128:0]         b_s;
    logic [131:0]         x_s;
    logic [DIGIT_W-1:0]   dig_s;
    logic [259:0]         pp_s;
    logic [132:0]         t_s;
    logic [130:0]         accn_s;
    logic [130:0]         fn_s;
    logic [129:0]         fr_s;
    logic [127:0]         tagn_s;

    assign key_acc_s = mac_bus.key_valid & key_ready_r;
    assign blk_acc_s = mac_bus.blk_valid & blk_ready_r;
    assign tag_acc_s = mac_bus.tag_ready & tag_valid_r;
    assign len_ok_s  = (mac_bus.blk_len != 5'd0) && (mac_bus.blk_len <= 5'd16);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:     if (key_acc_s) next_s = WAIT_BLK; else next_s = IDLE;
            WAIT_BLK: begin
                if (blk_acc_s) begin
                    if (len_ok_s)              next_s = ADD;
                    else if (mac_bus.blk_last) next_s = FIN1;
                    else                       next_s = WAIT_BLK;
                end else begin
                    next_s = WAIT_BLK;
                end
            end
            ADD:      next_s = MUL;
            MUL:      if (k_r == 8'(N - 1)) next_s = RED1; else next_s = MUL;
            RED1:     next_s = RED2;
            RED2:     if (last_r) next_s = FIN1; else next_s = WAIT_BLK;
            FIN1:     next_s = FIN2;
            FIN2:     next_s = OUT;
            OUT:      if (tag_acc_s) next_s = IDLE; else next_s = OUT;
            default:  next_s = IDLE;
        endcase
    end

    // Arithmetic for each datapath step; the padding bit sits just above the last valid byte.
    always_comb begin
        b_s    = {1'b0, data_r & byte_mask(len_r)} + (129'd1 << {len_r, 3'b000});
        x_s    = {1'b0, acc_r} + {3'b000, b_s};
        dig_s  = DIGIT_W'(r_r >> (32'(k_r) * DIGIT_W));
        pp_s   = (260'(x_r) * 260'(dig_s)) << (32'(k_r) * DIGIT_W);
        t_s    = 133'(p_r[129:0]) + 133'(p_r[259:130]) * 133'd5;
        accn_s = 131'(t_r[129:0]) + 131'(t_r[132:130]) * 131'd5;
        fn_s   = 131'(acc_r[129:0]) + (acc_r[130] ? 131'd5 : 131'd0);
        fr_s   = (f_r >= 131'(P_MOD)) ? 130'(f_r - 131'(P_MOD)) : f_r[129:0];
        tagn_s = 128'(fr_s) + s_r;
    end

    // Datapath registers, key state and status counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_r         <= 128'd0;
            s_r         <= 128'd0;
            acc_r       <= 131'd0;
            x_r         <= 132'd0;
            p_r         <= 260'd0;
            t_r         <= 133'd0;
            f_r         <= 131'd0;
            k_r         <= 8'd0;
            data_r      <= 128'd0;
            len_r       <= 5'd0;
            last_r      <= 1'b0;
            tag_r       <= 128'd0;
            len_err_r   <= 1'b0;
            blk_count_r <= {COUNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (key_acc_s) begin
                        r_r         <= mac_bus.key[127:0] & R_CLAMP;
                        s_r         <= mac_bus.key[255:128];
                        acc_r       <= 131'd0;
                        blk_count_r <= {COUNT_W{1'b0}};
                        len_err_r   <= 1'b0;
                    end
                end
                WAIT_BLK: begin
                    if (blk_acc_s) begin
                        data_r <= mac_bus.blk_data;
                        len_r  <= mac_bus.blk_len;
                        last_r <= mac_bus.blk_last;
                        if (!len_ok_s) len_err_r <= 1'b1;
                    end
                end
                ADD: begin
                    x_r <= x_s;
                    p_r <= 260'd0;
                    k_r <= 8'd0;
                end
                MUL: begin
                    p_r <= p_r + pp_s;
                    k_r <= k_r + 8'd1;
                end
                RED1: t_r <= t_s;
                RED2: begin
                    acc_r <= accn_s;
                    if (blk_count_r != {COUNT_W{1'b1}}) begin
                        blk_count_r <= blk_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
                    end
                end
                FIN1: f_r   <= fn_s;
                FIN2: tag_r <= tagn_s;
                default: begin
                end
            endcase
        end
    end

    // Handshake/status outputs follow the state being entered, so they line up with state_r.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_ready_r <= 1'b0;
            blk_ready_r <= 1'b0;
            tag_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            key_ready_r <= (next_s == IDLE);
            blk_ready_r <= (next_s == WAIT_BLK);
            tag_valid_r <= (next_s == OUT);
            busy_r      <= (next_s != IDLE);
        end
    end

    assign mac_bus.key_ready = key_ready_r;
    assign mac_bus.blk_ready = blk_ready_r;
    assign mac_bus.tag_valid = tag_valid_r;
    assign mac_bus.tag       = tag_r;
    assign busy              = busy_r;
    assign len_err           = len_err_r;
    assign blk_count         = blk_count_r;

endmodule

// File: tb/tb_poly1305_mac_core.sv
// Directed bench for poly1305_mac_core: RFC 8439 vector at every digit width,
// reduction wrap, backpressure, illegal lengths and mid-block reset.
module tb_poly1305_mac_core;

    localparam logic [127:0] RFC_R   = 128'ha806d542fe52447f336d555778bed685;
    localparam logic [127:0] RFC_S   = 128'h1bf54941aff6bf4afdb20dfb8a800301;
    localparam logic [255:0] RFC_KEY = {RFC_S, RFC_R};
    localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
    localparam logic [127:0] RFC_B0  = 128'h6f4620636968706172676f7470797243;
    localparam logic [127:0] RFC_B1  = 128'h6f7247206863726165736552206d7572;
    localparam logic [127:0] RFC_B2  = 128'hdeadbeefcafef00d5a5a5a5a12347075;
    localparam logic [127:0] ONES    = {16{8'hff}};
    localparam logic [127:0] S_Z     = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] S_Y     = 128'h55aa55aa00ff00ff13579bdf2468ace0;
    localparam logic [127:0] CLAMP   = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy;
    logic        len_err;
    logic [31:0] blk_count;
    int          n_cmp = 0;
    int          n_mis = 0;

    logic [127:0] m_data [4];
    int           m_len  [4];

    always #5 clk = ~clk;

    poly1305_mac_core_if bus ();

    poly1305_mac_core #(.DIGIT_W(32), .COUNT_W(32)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mac_bus   (bus),
        .busy      (busy),
        .len_err   (len_err),
        .blk_count (blk_count)
    );

    // Alternate digit widths, each fed the same stream; a block is withheld from an
    // instance once it has taken it.
    logic         a_key_valid = 1'b0;
    logic [255:0] a_key = 256'd0;
    logic         a_blk_valid = 1'b0;
    logic [127:0] a_blk_data = 128'd0;
    logic [4:0]   a_blk_len = 5'd0;
    logic         a_blk_last = 1'b0;
    logic         a_clr = 1'b0;
    logic [3:0]   a_took;
    logic [3:0]   a_busy;
    logic [3:0]   a_lerr;
    logic [127:0] a_tag [4];
    int           a_low [4];
    logic [31:0]  a_cnt [4];
    int           alt_low_exp [4] = '{19, 11, 5, 4};

    for (genvar g = 0; g < 4; g++) begin : g_alt
        localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 64 : 128;
        poly1305_mac_core_if alt_bus ();
        logic        took = 1'b0;
        logic        counting = 1'b0;
        logic        measured = 1'b0;
        int          low = 0;
        logic        busy_o;
        logic        len_err_o;
        logic [31:0] cnt_o;

        assign alt_bus.key_valid = a_key_valid;
        assign alt_bus.key       = a_key;
        assign alt_bus.blk_valid = a_blk_valid & ~took;
        assign alt_bus.blk_data  = a_blk_data;
        assign alt_bus.blk_len   = a_blk_len;
        assign alt_bus.blk_last  = a_blk_last;
        assign alt_bus.tag_ready = 1'b1;
        assign a_took[g] = took;
        assign a_busy[g] = busy_o;
        assign a_lerr[g] = len_err_o;
        assign a_tag[g]  = alt_bus.tag;
        assign a_low[g]  = low;
        assign a_cnt[g]  = cnt_o;

        always @(posedge clk) begin
            if (a_clr) took <= 1'b0;
            else if (alt_bus.blk_valid && alt_bus.blk_ready) took <= 1'b1;
            if (!measured) begin
                if (counting) begin
                    if (alt_bus.blk_ready) measured <= 1'b1;
                    else low <= low + 1;
                end else if (alt_bus.blk_valid && alt_bus.blk_ready) begin
                    counting <= 1'b1;
                end
            end
        end

        poly1305_mac_core #(.DIGIT_W(W), .COUNT_W(32)) u_alt (
            .clk       (clk),
            .reset_n   (reset_n),
            .mac_bus   (alt_bus),
            .busy      (busy_o),
            .len_err   (len_err_o),
            .blk_count (cnt_o)
        );
    end

    // Straightforward reference: acc = ((acc + block) * r) mod p with full-width modulo.
    function automatic logic [127:0] mac_ref(input logic [127:0] rk, input logic [127:0] sk,
                                             input int nb);
        logic [259:0] a, bl, rr, pm;
        rr = {132'd0, rk & CLAMP};
        pm = {130'd0, 2'b11, {31{4'hf}}, 4'hb};
        a  = 260'd0;
        for (int i = 0; i < nb; i++) begin
            bl = 260'd0;
            for (int j = 0; j < m_len[i]; j++) bl[8*j +: 8] = m_data[i][8*j +: 8];
            bl = bl + (260'd1 << (8 * m_len[i]));
            a  = ((a + bl) * rr) % pm;
        end
        a = a + {132'd0, sk};
        return a[127:0];
    endfunction

    task automatic check(input string name, input logic [259:0] obs, input logic [259:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic load_key(input logic [255:0] k);
        bus.key = k;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.key_ready; i++) @(negedge clk);
        check("key_ready_wait", 260'(bus.key_ready), 260'd1);
        @(negedge clk);
        bus.key_valid = 1'b0;
        check("blk_ready_after_key", 260'(bus.blk_ready), 260'd1);
        check("len_err_cleared", 260'(len_err), 260'd0);
        check("blk_count_cleared", 260'(blk_count), 260'd0);
    endtask

    task automatic send_only(input logic [127:0] d, input logic [4:0] l, input logic last);
        bus.blk_data  = d;
        bus.blk_len   = l;
        bus.blk_last  = last;
        bus.blk_valid = 1'b1;
        for (int i = 0; i < 100 && !bus.blk_ready; i++) @(negedge clk);
        check("blk_ready_wait", 260'(bus.blk_ready), 260'd1);
        @(negedge clk);
        bus.blk_valid = 1'b0;
        bus.blk_last  = 1'b0;
    endtask

    // Returns the cycles after acceptance until blk_ready (or tag_valid for a last block) rises.
    task automatic send_blk(input logic [127:0] d, input logic [4:0] l, input logic last,
                            output int wait_n);
        send_only(d, l, last);
        wait_n = 0;
        if (last) begin
            while (!bus.tag_valid && wait_n < 400) begin wait_n++; @(negedge clk); end
        end else begin
            while (!bus.blk_ready && wait_n < 400) begin wait_n++; @(negedge clk); end
        end
    endtask

    task automatic take_tag();
        bus.tag_ready = 1'b1;
        @(negedge clk);
        bus.tag_ready = 1'b0;
    endtask

    task automatic rfc_run(input string name);
        int n;
        load_key(RFC_KEY);
        send_blk(RFC_B0, 5'd16, 1'b0, n);
        check({name, "_blk0_ready_low"}, 260'(n), 260'd7);
        send_blk(RFC_B1, 5'd16, 1'b0, n);
        check({name, "_blk1_ready_low"}, 260'(n), 260'd7);
        send_blk(RFC_B2, 5'd2, 1'b1, n);
        check({name, "_last_to_tag"}, 260'(n), 260'd9);
        check({name, "_tag"}, 260'(bus.tag), 260'(RFC_TAG));
        check({name, "_blk_count"}, 260'(blk_count), 260'd3);
        check({name, "_len_err"}, 260'(len_err), 260'd0);
        check({name, "_busy_out"}, 260'(busy), 260'd1);
        take_tag();
        check({name, "_tag_valid_drop"}, 260'(bus.tag_valid), 260'd0);
        check({name, "_key_ready_back"}, 260'(bus.key_ready), 260'd1);
        check({name, "_tag_held"}, 260'(bus.tag), 260'(RFC_TAG));
    endtask

    initial begin
        int n;
        logic [127:0] t0;
        logic [127:0] exp_tag;
        bus.key_valid = 1'b0;
        bus.key       = 256'd0;
        bus.blk_valid = 1'b0;
        bus.blk_data  = 128'd0;
        bus.blk_len   = 5'd0;
        bus.blk_last  = 1'b0;
        bus.tag_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_key_ready", 260'(bus.key_ready), 260'd0);
        check("rst_outputs", 260'({bus.blk_ready, bus.tag_valid, busy, len_err, blk_count, bus.tag}), 260'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_key_ready", 260'(bus.key_ready), 260'd1);
        check("post_rst_busy", 260'(busy), 260'd0);

        // RFC vector on DIGIT_W = 8, 16, 64, 128
        a_key = RFC_KEY;
        a_key_valid = 1'b1;
        @(negedge clk);
        a_key_valid = 1'b0;
        check("alt_busy_after_key", 260'(a_busy), 260'hf);
        for (int b = 0; b < 3; b++) begin
            a_blk_data = (b == 0) ? RFC_B0 : (b == 1) ? RFC_B1 : RFC_B2;
            a_blk_len  = (b == 2) ? 5'd2 : 5'd16;
            a_blk_last = (b == 2);
            a_clr = 1'b1;
            @(negedge clk);
            a_clr = 1'b0;
            a_blk_valid = 1'b1;
            for (int i = 0; i < 200 && a_took != 4'hf; i++) @(negedge clk);
            check("alt_block_taken", 260'(a_took), 260'hf);
            a_blk_valid = 1'b0;
        end
        for (int i = 0; i < 200 && a_busy != 4'h0; i++) @(negedge clk);
        check("alt_idle", 260'(a_busy), 260'd0);
        check("alt_len_err", 260'(a_lerr), 260'd0);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("alt%0d_tag", g), 260'(a_tag[g]), 260'(RFC_TAG));
            check($sformatf("alt%0d_ready_low", g), 260'(a_low[g]), 260'(alt_low_exp[g]));
            check($sformatf("alt%0d_blk_count", g), 260'(a_cnt[g]), 260'd3);
        end

        // RFC vector on DIGIT_W = 32 with cycle timing
        rfc_run("rfc");

        // Wrap/reduction with backpressure and a key offered during OUT
        for (int i = 0; i < 3; i++) begin m_data[i] = ONES; m_len[i] = 16; end
        exp_tag = mac_ref(ONES, 128'd0, 3);
        load_key({128'd0, ONES});
        send_blk(ONES, 5'd16, 1'b0, n);
        send_blk(ONES, 5'd16, 1'b0, n);
        send_blk(ONES, 5'd16, 1'b1, n);
        check("wrap_last_to_tag", 260'(n), 260'd9);
        t0 = bus.tag;
        bus.key = RFC_KEY;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_tag_valid", 260'(bus.tag_valid), 260'd1);
            check("bp_tag_stable", 260'(bus.tag), 260'(t0));
            check("bp_key_ready", 260'(bus.key_ready), 260'd0);
            @(negedge clk);
        end
        check("wrap_tag", 260'(bus.tag), 260'(exp_tag));
        check("wrap_blk_count", 260'(blk_count), 260'd3);
        take_tag();
        check("bp_tag_valid_drop", 260'(bus.tag_valid), 260'd0);
        check("bp_key_ready_next", 260'(bus.key_ready), 260'd1);
        check("bp_tag_hold", 260'(bus.tag), 260'(exp_tag));
        @(negedge clk);
        bus.key_valid = 1'b0;
        check("b2b_key_blk_ready", 260'(bus.blk_ready), 260'd1);
        check("b2b_key_busy", 260'(busy), 260'd1);

        // Illegal lengths 0 and 20, then a 2-byte last block
        m_data[0] = RFC_B2;
        m_len[0]  = 2;
        exp_tag = mac_ref(RFC_R, RFC_S, 1);
        send_blk(RFC_B0, 5'd0, 1'b0, n);
        check("len0_ready_low", 260'(n), 260'd0);
        check("len0_len_err", 260'(len_err), 260'd1);
        check("len0_blk_count", 260'(blk_count), 260'd0);
        send_blk(RFC_B1, 5'd20, 1'b0, n);
        check("len20_ready_low", 260'(n), 260'd0);
        send_blk(RFC_B2, 5'd2, 1'b1, n);
        check("illegal_last_to_tag", 260'(n), 260'd9);
        check("illegal_tag", 260'(bus.tag), 260'(exp_tag));
        check("illegal_blk_count", 260'(blk_count), 260'd1);
        check("illegal_len_err", 260'(len_err), 260'd1);
        take_tag();

        // r = 0 with an all-zero block: tag is s
        load_key({S_Z, 128'd0});
        send_blk(128'd0, 5'd16, 1'b1, n);
        check("zero_r_tag", 260'(bus.tag), 260'(S_Z));
        take_tag();

        // Lone illegal last block: tag is s after 2 cycles, nothing absorbed
        load_key({S_Y, ONES});
        send_blk(ONES, 5'd0, 1'b1, n);
        check("illegal_only_to_tag", 260'(n), 260'd2);
        check("illegal_only_tag", 260'(bus.tag), 260'(S_Y));
        check("illegal_only_count", 260'(blk_count), 260'd0);
        check("illegal_only_len_err", 260'(len_err), 260'd1);
        take_tag();

        // Reset during MUL of block 2
        load_key(RFC_KEY);
        send_blk(RFC_B0, 5'd16, 1'b0, n);
        send_only(RFC_B1, 5'd16, 1'b0);
        @(negedge clk);
        check("pre_rst_busy", 260'(busy), 260'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_outputs", 260'({bus.key_ready, bus.blk_ready, bus.tag_valid, busy, len_err, blk_count, bus.tag}), 260'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_key_ready", 260'(bus.key_ready), 260'd1);
        check("mid_rst_others", 260'({bus.blk_ready, bus.tag_valid, busy, len_err, blk_count, bus.tag}), 260'd0);
        rfc_run("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
